// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: writeback-stage initiator for CSR instruction accesses and
// for exception/ertn commit into the CSR file. One operation is in flight
// at a time: IDLE accepts it, ACCESS drives the CSR file for a single cycle,
// and RESP hands the old CSR value back for register writeback.
module csr_access_ctrl #(
  parameter logic [5:0] ECODE_INT = 6'h00,
  parameter logic [5:0] ECODE_SYS = 6'h0B,
  parameter logic [5:0] ECODE_BRK = 6'h0C,
  parameter logic [5:0] ECODE_INE = 6'h0D
) (
  input  logic        clk,
  input  logic        rst,
  // request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [13:0] req_csr_num,
  input  logic [31:0] req_rd_val,
  input  logic [31:0] req_rj_val,
  input  logic [31:0] req_pc,
  input  logic        req_ex,
  input  logic [5:0]  req_ecode,
  input  logic [8:0]  req_esubcode,
  input  logic        has_int,
  // CSR file access
  output logic        csr_re,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  // exception / return commit
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_epc,
  output logic        ertn_flush,
  output logic        flush_out,
  // response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_wen
);

  localparam logic [2:0] OP_CSRRD   = 3'd1;
  localparam logic [2:0] OP_CSRWR   = 3'd2;
  localparam logic [2:0] OP_CSRXCHG = 3'd3;
  localparam logic [2:0] OP_ERTN    = 3'd4;
  localparam logic [2:0] OP_SYSCALL = 3'd5;
  localparam logic [2:0] OP_BREAK   = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q,   state_d;
  logic [2:0]  op_q,      op_d;
  logic [13:0] num_q,     num_d;
  logic [31:0] rd_q,      rd_d;
  logic [31:0] rj_q,      rj_d;
  logic [31:0] pc_q,      pc_d;
  logic        ex_q,      ex_d;
  logic [5:0]  ecode_q,   ecode_d;
  logic [8:0]  esub_q,    esub_d;
  logic [31:0] rdata_q,   rdata_d;

  logic        op_reserved;

  assign op_reserved = (op_q == 3'd0) || (op_q == 3'd7);

  // State and latched request fields; reset also scrubs the latched operation
  // so a discarded response can never leak out later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      num_q   <= 14'd0;
      rd_q    <= 32'd0;
      rj_q    <= 32'd0;
      pc_q    <= 32'd0;
      ex_q    <= 1'b0;
      ecode_q <= 6'd0;
      esub_q  <= 9'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      num_q   <= num_d;
      rd_q    <= rd_d;
      rj_q    <= rj_d;
      pc_q    <= pc_d;
      ex_q    <= ex_d;
      ecode_q <= ecode_d;
      esub_q  <= esub_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: accept in IDLE, one ACCESS cycle, then RESP unless the
  // access turned into an exception or ertn (those return straight to IDLE).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    num_d   = num_q;
    rd_d    = rd_q;
    rj_d    = rj_q;
    pc_d    = pc_q;
    ex_d    = ex_q;
    ecode_d = ecode_q;
    esub_d  = esub_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          num_d   = req_csr_num;
          rd_d    = req_rd_val;
          rj_d    = req_rj_val;
          pc_d    = req_pc;
          ex_d    = req_ex;
          ecode_d = req_ecode;
          esub_d  = req_esubcode;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (flush_out) begin
          state_d = IDLE;
        end else begin
          // csr_rvalue is the pre-write value: the write lands on this edge.
          rdata_d = csr_rvalue;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ACCESS-cycle decode: interrupt beats upstream exception beats decoded
  // exceptions beats ertn beats a plain CSR access; everything is 0 elsewhere.
  always_comb begin
    csr_re      = 1'b0;
    csr_num     = 14'd0;
    csr_we      = 1'b0;
    csr_wmask   = 32'd0;
    csr_wvalue  = 32'd0;
    wb_ex       = 1'b0;
    wb_ecode    = 6'd0;
    wb_esubcode = 9'd0;
    wb_epc      = 32'd0;
    ertn_flush  = 1'b0;
    flush_out   = 1'b0;
    if (state_q == ACCESS) begin
      if (has_int) begin
        wb_ex    = 1'b1;
        wb_ecode = ECODE_INT;
      end else if (ex_q) begin
        wb_ex       = 1'b1;
        wb_ecode    = ecode_q;
        wb_esubcode = esub_q;
      end else if (op_reserved) begin
        wb_ex    = 1'b1;
        wb_ecode = ECODE_INE;
      end else if (op_q == OP_SYSCALL) begin
        wb_ex    = 1'b1;
        wb_ecode = ECODE_SYS;
      end else if (op_q == OP_BREAK) begin
        wb_ex    = 1'b1;
        wb_ecode = ECODE_BRK;
      end else if (op_q == OP_ERTN) begin
        ertn_flush = 1'b1;
      end else begin
        csr_re  = 1'b1;
        csr_num = num_q;
        if (op_q == OP_CSRWR) begin
          csr_we     = 1'b1;
          csr_wmask  = 32'hFFFF_FFFF;
          csr_wvalue = rd_q;
        end else if (op_q == OP_CSRXCHG) begin
          csr_we     = 1'b1;
          csr_wmask  = rj_q;
          csr_wvalue = rd_q;
        end
      end
      if (wb_ex) begin
        wb_epc = pc_q;
      end
      flush_out = wb_ex | ertn_flush;
    end
  end

  // Handshake and response outputs follow the state directly.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_wen   = (state_q == RESP);
    rsp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: a small CSR file is modelled around the DUT,
// directed scenarios are followed by random operations, and every cycle of
// interest is compared against a rule-level model of expected behaviour.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [13:0] req_csr_num;
  logic [31:0] req_rd_val;
  logic [31:0] req_rj_val;
  logic [31:0] req_pc;
  logic        req_ex;
  logic [5:0]  req_ecode;
  logic [8:0]  req_esubcode;
  logic        has_int;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_epc;
  logic        ertn_flush;
  logic        flush_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_wen;

  int checks   = 0;
  int failures = 0;

  // CSR file seen by the DUT, and the bench's own expectation of its contents
  logic [31:0] csr_mem    [0:16383];
  logic [31:0] shadow_mem [0:16383];

  typedef struct packed {
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        ertn;
    logic        re;
    logic        we;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic        resp;
  } exp_t;

  csr_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr_num(req_csr_num), .req_rd_val(req_rd_val), .req_rj_val(req_rj_val),
    .req_pc(req_pc), .req_ex(req_ex), .req_ecode(req_ecode),
    .req_esubcode(req_esubcode), .has_int(has_int),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_epc(wb_epc), .ertn_flush(ertn_flush), .flush_out(flush_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_wen(rsp_wen)
  );

  always #5 clk = ~clk;

  assign csr_rvalue = csr_mem[csr_num];

  always @(posedge clk) begin
    if (csr_we) begin
      csr_mem[csr_num] <= (csr_mem[csr_num] & ~csr_wmask) | (csr_wvalue & csr_wmask);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected ACCESS-cycle behaviour from the operation's rules
  function automatic exp_t model(input logic [2:0] op, input logic ex, input logic [5:0] ec,
                                 input logic [8:0] es, input logic intr,
                                 input logic [31:0] rd, input logic [31:0] rj);
    exp_t e;
    e = '0;
    if (intr) begin
      e.ex = 1'b1; e.ecode = 6'h00;
    end else if (ex) begin
      e.ex = 1'b1; e.ecode = ec; e.esub = es;
    end else if (op == 3'd0 || op == 3'd7) begin
      e.ex = 1'b1; e.ecode = 6'h0D;
    end else if (op == 3'd5) begin
      e.ex = 1'b1; e.ecode = 6'h0B;
    end else if (op == 3'd6) begin
      e.ex = 1'b1; e.ecode = 6'h0C;
    end else if (op == 3'd4) begin
      e.ertn = 1'b1;
    end else begin
      e.re   = 1'b1;
      e.resp = 1'b1;
      if (op != 3'd1) begin
        e.we     = 1'b1;
        e.wmask  = (op == 3'd2) ? 32'hFFFF_FFFF : rj;
        e.wvalue = rd;
      end
    end
    return e;
  endfunction

  task automatic drive_req(input logic [2:0] op, input logic [13:0] num, input logic [31:0] rd,
                           input logic [31:0] rj, input logic [31:0] pc, input logic ex,
                           input logic [5:0] ec, input logic [8:0] es);
    req_valid = 1'b1; req_op = op; req_csr_num = num; req_rd_val = rd; req_rj_val = rj;
    req_pc = pc; req_ex = ex; req_ecode = ec; req_esubcode = es;
  endtask

  task automatic scramble_req();
    req_valid = 1'($urandom); req_op = 3'($urandom); req_csr_num = 14'($urandom);
    req_rd_val = $urandom; req_rj_val = $urandom; req_pc = $urandom;
    req_ex = 1'($urandom); req_ecode = 6'($urandom); req_esubcode = 9'($urandom);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_wen"},   32'(rsp_wen),   32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata,      32'd0);
    chk({tag, "_wb_ex"},     32'(wb_ex),     32'd0);
    chk({tag, "_ertn"},      32'(ertn_flush), 32'd0);
    chk({tag, "_flush"},     32'(flush_out), 32'd0);
    chk({tag, "_csr_re"},    32'(csr_re),    32'd0);
    chk({tag, "_csr_we"},    32'(csr_we),    32'd0);
    chk({tag, "_wb_epc"},    wb_epc,         32'd0);
  endtask

  // One complete operation; entered and left just after a falling edge.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [13:0] num,
                       input logic [31:0] rd, input logic [31:0] rj, input logic [31:0] pc,
                       input logic ex, input logic [5:0] ec, input logic [8:0] es,
                       input logic intr, input int hold);
    exp_t e;
    logic [31:0] old;
    e = model(op, ex, ec, es, intr, rd, rj);
    chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    drive_req(op, num, rd, rj, pc, ex, ec, es);
    @(posedge clk); #1;
    scramble_req();
    has_int = intr;
    @(negedge clk);
    chk({tag, "_re"},     32'(csr_re),      32'(e.re));
    chk({tag, "_num"},    32'(csr_num),     e.re ? 32'(num) : 32'd0);
    chk({tag, "_we"},     32'(csr_we),      32'(e.we));
    chk({tag, "_wmask"},  csr_wmask,        e.wmask);
    chk({tag, "_wvalue"}, csr_wvalue,       e.wvalue);
    chk({tag, "_wb_ex"},  32'(wb_ex),       32'(e.ex));
    chk({tag, "_ecode"},  32'(wb_ecode),    32'(e.ecode));
    chk({tag, "_esub"},   32'(wb_esubcode), 32'(e.esub));
    chk({tag, "_epc"},    wb_epc,           e.ex ? pc : 32'd0);
    chk({tag, "_ertn"},   32'(ertn_flush),  32'(e.ertn));
    chk({tag, "_flush"},  32'(flush_out),   32'(e.ex | e.ertn));
    chk({tag, "_acc_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_acc_rspv"},  32'(rsp_valid), 32'd0);
    old = shadow_mem[num];
    if (e.we) shadow_mem[num] = (old & ~e.wmask) | (e.wvalue & e.wmask);
    @(posedge clk); #1;
    has_int = 1'($urandom);
    @(negedge clk);
    if (e.resp) begin
      rsp_ready = 1'b0;
      for (int i = 0; i <= hold; i++) begin
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rsp_wen"},   32'(rsp_wen),   32'd1);
        chk({tag, "_rsp_rdata"}, rsp_rdata,      old);
        chk({tag, "_rsp_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_wb_ex"}, 32'(wb_ex | flush_out | csr_we), 32'd0);
        if (i < hold) @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_done_rspv"},  32'(rsp_valid), 32'd0);
      chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    end else begin
      chk({tag, "_post_wb_ex"}, 32'(wb_ex),      32'd0);
      chk({tag, "_post_ertn"},  32'(ertn_flush), 32'd0);
      chk({tag, "_post_flush"}, 32'(flush_out),  32'd0);
      chk({tag, "_post_rspv"},  32'(rsp_valid),  32'd0);
      chk({tag, "_post_ready"}, 32'(req_ready),  32'd1);
    end
    req_valid = 1'b0;
    has_int   = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 16384; i++) begin
      v = $urandom;
      csr_mem[i]    = v;
      shadow_mem[i] = v;
    end
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_csr_num = 14'd0;
    req_rd_val = 32'd0; req_rj_val = 32'd0; req_pc = 32'd0; req_ex = 1'b0;
    req_ecode = 6'd0; req_esubcode = 9'd0; has_int = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // CSRWR with a known old value
    csr_mem[14'h30] = 32'h1234_5678; shadow_mem[14'h30] = 32'h1234_5678;
    do_op("csrwr", 3'd2, 14'h30, 32'hDEAD_BEEF, 32'h0, 32'h1C00_0000, 1'b0, 6'd0, 9'd0, 1'b0, 0);
    // CSRXCHG with back-pressure on the response
    csr_mem[14'h31] = 32'h5555_1234; shadow_mem[14'h31] = 32'h5555_1234;
    do_op("xchg", 3'd3, 14'h31, 32'hAAAA_AAAA, 32'h0000_FF00, 32'h1C00_0004, 1'b0, 6'd0, 9'd0, 1'b0, 5);
    // readback proves the masked write landed
    do_op("xchg_rb", 3'd1, 14'h31, 32'h0, 32'h0, 32'h1C00_0008, 1'b0, 6'd0, 9'd0, 1'b0, 0);
    do_op("syscall", 3'd5, 14'h0, 32'h0, 32'h0, 32'h1C00_0100, 1'b0, 6'd0, 9'd0, 1'b0, 0);
    do_op("int_wins", 3'd2, 14'h30, 32'h0BAD_0BAD, 32'h0, 32'h1C00_0200, 1'b1, 6'h08, 9'h5, 1'b1, 0);
    do_op("upstream_ex", 3'd1, 14'h30, 32'h0, 32'h0, 32'h1C00_0204, 1'b1, 6'h08, 9'h1A5, 1'b0, 0);
    do_op("break", 3'd6, 14'h0, 32'h0, 32'h0, 32'h1C00_0208, 1'b0, 6'd0, 9'd0, 1'b0, 0);
    do_op("ertn", 3'd4, 14'h0, 32'h0, 32'h0, 32'h1C00_0300, 1'b0, 6'd0, 9'd0, 1'b0, 0);
    do_op("op7", 3'd7, 14'h0, 32'h0, 32'h0, 32'h1C00_0400, 1'b0, 6'd0, 9'd0, 1'b0, 0);
    do_op("op0", 3'd0, 14'h0, 32'h0, 32'h0, 32'h1C00_0404, 1'b0, 6'd0, 9'd0, 1'b0, 0);

    // Reset while a CSRRD response is pending
    drive_req(3'd1, 14'h30, 32'h0, 32'h0, 32'h1C00_0500, 1'b0, 6'd0, 9'd0);
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_resp_pre_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_quiet("rst_resp");
    @(negedge clk);
    chk_quiet("rst_resp_after");

    // Reset during ACCESS of a syscall with an interrupt pending: no pulse afterwards
    drive_req(3'd5, 14'h0, 32'h0, 32'h0, 32'h1C00_0600, 1'b0, 6'd0, 9'd0);
    @(posedge clk); #1; req_valid = 1'b0; has_int = 1'b1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; has_int = 1'b0;
    @(negedge clk);
    chk_quiet("rst_access");

    // Random operations
    for (int n = 0; n < 60; n++) begin
      do_op("rand", 3'($urandom_range(0, 7)), 14'($urandom_range(0, 15)), $urandom, $urandom,
            $urandom, ($urandom_range(0, 7) == 0), 6'($urandom), 9'($urandom),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
